afe_spi_readback: RTL and testbench

Passive SPI receiver that snoops the write-only AFE attenuator SPI lines (AFE_SPI_CLK/SDI/LE, one set per AFE) inside the dsbpm top, deserializes each frame and holds the last word per channel in shadow registers. Software thereby gets readback of the attenuation actually shifted out to the AFE, plus framing-error and frame-count status. It sits alongside the SPI master on sysClk and observes the same output nets; it never drives them.

---
 rtl/afe_spi_pkg.sv | 21 ++
 rtl/afe_spi_readback_if.sv | 32 +++
 rtl/afe_spi_rx_chan.sv | 145 ++++++++++++++
 rtl/afe_spi_readback.sv | 41 ++++
 tb/tb_afe_spi_readback.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/afe_spi_pkg.sv
// ============================================================================
// afe_spi_pkg : shared types and constants for the AFE SPI readback snooper
// Rev 1.0
// ============================================================================
`default_nettype none

package afe_spi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    // Bit counter must hold WORD_WIDTH+1 (saturation point for long frames)
    function automatic int bit_count_width(input int word_width);
        return $clog2(word_width + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/afe_spi_readback_if.sv
// ============================================================================
// afe_spi_readback_if : observed AFE SPI lines plus shadow/status readback
// Rev 1.0
// ============================================================================
`default_nettype none

interface afe_spi_readback_if #(
    parameter int CHANNEL_COUNT = 2,
    parameter int WORD_WIDTH    = 8,
    parameter int COUNT_WIDTH   = 16
);
    logic [CHANNEL_COUNT-1:0]             spiClk;
    logic [CHANNEL_COUNT-1:0]             spiSdi;
    logic [CHANNEL_COUNT-1:0]             spiLe;
    logic [CHANNEL_COUNT-1:0]             errClear;
    logic [CHANNEL_COUNT*WORD_WIDTH-1:0]  rxWord;
    logic [CHANNEL_COUNT-1:0]             rxValid;
    logic [CHANNEL_COUNT-1:0]             rxErr;
    logic [CHANNEL_COUNT*COUNT_WIDTH-1:0] rxCount;

    modport master (
        output spiClk, spiSdi, spiLe, errClear,
        input  rxWord, rxValid, rxErr, rxCount
    );

    modport slave (
        input  spiClk, spiSdi, spiLe, errClear,
        output rxWord, rxValid, rxErr, rxCount
    );
endinterface

`default_nettype wire

// File: rtl/afe_spi_rx_chan.sv
// ============================================================================
// afe_spi_rx_chan : one passive SPI receive channel (sync, edge detect, FSM)
// Rev 1.0
// ============================================================================
`default_nettype none

module afe_spi_rx_chan
    import afe_spi_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   spi_clk,
    input  wire logic                   spi_sdi,
    input  wire logic                   spi_le,
    input  wire logic                   err_clear,
    output logic      [WORD_WIDTH-1:0]  rx_word,
    output logic                        rx_valid,
    output logic                        rx_err,
    output logic      [COUNT_WIDTH-1:0] rx_count
);

    localparam int              CNT_W    = bit_count_width(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_WIDTH + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] le_sync;
    logic                   clk_hist;
    logic                   le_hist;
    logic                   sclk_rise;
    logic                   le_fall;
    logic                   le_rise;
    logic                   sdi_bit;

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic [WORD_WIDTH-1:0]  shreg;
    logic [WORD_WIDTH-1:0]  shreg_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       bit_cnt_nxt;
    logic                   frame_good;
    logic                   frame_bad;
    logic [COUNT_WIDTH-1:0] frame_count;

    // Synchronizers reset low so a reset taken mid-frame (LE low) never
    // produces a spurious LE falling edge on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '0;
            sdi_sync  <= '0;
            le_sync   <= '0;
            clk_hist  <= 1'b0;
            le_hist   <= 1'b0;
            sclk_rise <= 1'b0;
            le_fall   <= 1'b0;
            le_rise   <= 1'b0;
            sdi_bit   <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            le_sync   <= {le_sync[SYNC_STAGES-2:0], spi_le};
            clk_hist  <= clk_sync[SYNC_STAGES-1];
            le_hist   <= le_sync[SYNC_STAGES-1];
            sclk_rise <= clk_sync[SYNC_STAGES-1] & ~clk_hist;
            le_fall   <= ~le_sync[SYNC_STAGES-1] & le_hist;
            le_rise   <= le_sync[SYNC_STAGES-1] & ~le_hist;
            sdi_bit   <= sdi_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // A coincident SCLK rise is shifted before LE rise closes the frame,
    // so the close decision looks at the updated count.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        frame_good  = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (le_fall) begin
                    state_nxt   = ST_SHIFT;
                    bit_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shreg_nxt = {shreg[WORD_WIDTH-2:0], sdi_bit};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
                if (le_rise) begin
                    state_nxt  = ST_IDLE;
                    frame_good = (bit_cnt_nxt == CNT_FULL);
                    frame_bad  = (bit_cnt_nxt != CNT_FULL);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_word     <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
            frame_count <= '0;
        end else begin
            rx_valid <= frame_good;
            if (frame_good) begin
                rx_word     <= shreg_nxt;
                frame_count <= frame_count + COUNT_WIDTH'(1);
            end
            // A new error wins over a simultaneous clear
            if (frame_bad) begin
                rx_err <= 1'b1;
            end else if (err_clear) begin
                rx_err <= 1'b0;
            end
        end
    end

    assign rx_count = frame_count;

endmodule

`default_nettype wire

// File: rtl/afe_spi_readback.sv
// ============================================================================
// afe_spi_readback : per-AFE snooping SPI receivers with shadow readback
// Rev 1.0
// ============================================================================
`default_nettype none

module afe_spi_readback
    import afe_spi_pkg::*;
#(
    parameter int CHANNEL_COUNT = 2,
    parameter int WORD_WIDTH    = 8,
    parameter int SYNC_STAGES   = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input wire logic          sysClk,
    input wire logic          sysReset_n,
    afe_spi_readback_if.slave bus
);

    for (genvar ch = 0; ch < CHANNEL_COUNT; ch++) begin : g_chan
        afe_spi_rx_chan #(
            .WORD_WIDTH  (WORD_WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_chan (
            .clk       (sysClk),
            .rst_n     (sysReset_n),
            .spi_clk   (bus.spiClk[ch]),
            .spi_sdi   (bus.spiSdi[ch]),
            .spi_le    (bus.spiLe[ch]),
            .err_clear (bus.errClear[ch]),
            .rx_word   (bus.rxWord[ch*WORD_WIDTH +: WORD_WIDTH]),
            .rx_valid  (bus.rxValid[ch]),
            .rx_err    (bus.rxErr[ch]),
            .rx_count  (bus.rxCount[ch*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_afe_spi_readback.sv
// ============================================================================
// tb_afe_spi_readback : randomized frames against a frame-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_afe_spi_readback;

    localparam int CC = 2;
    localparam int WW = 8;
    localparam int SS = 3;
    localparam int CW = 16;

    logic sysClk;
    logic sysReset_n;

    afe_spi_readback_if #(.CHANNEL_COUNT(CC), .WORD_WIDTH(WW), .COUNT_WIDTH(CW)) bus ();

    afe_spi_readback #(
        .CHANNEL_COUNT (CC),
        .WORD_WIDTH    (WW),
        .SYNC_STAGES   (SS),
        .COUNT_WIDTH   (CW)
    ) u_dut (
        .sysClk     (sysClk),
        .sysReset_n (sysReset_n),
        .bus        (bus)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what software should read back per channel
    logic [WW-1:0] m_word [CC];
    logic [CW-1:0] m_cnt  [CC];
    logic          m_err  [CC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    int vrun [CC];
    always @(negedge sysClk) begin
        for (int c = 0; c < CC; c++) begin
            if (bus.rxValid[c] === 1'b1) begin
                vrun[c]++;
                check($sformatf("valid_width%0d", c), vrun[c], 1);
            end else begin
                vrun[c] = 0;
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CC; c++) begin
            m_word[c] = '0;
            m_cnt[c]  = '0;
            m_err[c]  = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CC; c++) begin
            check($sformatf("word%0d", c),  bus.rxWord[c*WW +: WW],  m_word[c]);
            check($sformatf("count%0d", c), bus.rxCount[c*CW +: CW], m_cnt[c]);
            check($sformatf("err%0d", c),   bus.rxErr[c],            m_err[c]);
        end
    endtask

    // Called right after LE is raised at a negedge; watches the result window
    task automatic finish_frame(input int ch, input bit good, input logic [WW-1:0] word,
                                input bit clr_in_err);
        int first;
        int pulses;
        first  = 0;
        pulses = 0;
        for (int k = 1; k <= SS + 6; k++) begin
            @(posedge sysClk);
            #1;
            if (clr_in_err && k == SS + 1) bus.errClear[ch] = 1'b1;
            if (clr_in_err && k == SS + 2) bus.errClear[ch] = 1'b0;
            if (bus.rxValid[ch] === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        if (good) begin
            m_word[ch] = word;
            m_cnt[ch]  = m_cnt[ch] + 1'b1;
            check("latency", first, SS + 2);
        end else begin
            m_err[ch] = 1'b1;
        end
        check("pulses", pulses, good ? 1 : 0);
        compare_all();
        @(negedge sysClk);
    endtask

    task automatic send_frame(input int ch, input logic [31:0] data, input int nbits,
                              input int phase, input bit coincide, input bit clr_in_err);
        bit good;
        good = (nbits == WW);
        bus.spiLe[ch] = 1'b0;
        wait_n(phase);
        for (int i = 0; i < nbits; i++) begin
            bus.spiSdi[ch] = data[nbits-1-i];
            wait_n(phase);
            bus.spiClk[ch] = 1'b1;
            if (coincide && i == nbits - 1) begin
                bus.spiLe[ch] = 1'b1;
            end else begin
                wait_n(phase);
                bus.spiClk[ch] = 1'b0;
            end
        end
        if (!(coincide && nbits > 0)) begin
            wait_n(phase);
            bus.spiLe[ch] = 1'b1;
        end
        finish_frame(ch, good, data[WW-1:0], clr_in_err);
        bus.spiClk[ch] = 1'b0;
    endtask

    task automatic clear_err(input int ch);
        bus.errClear[ch] = 1'b1;
        @(negedge sysClk);
        bus.errClear[ch] = 1'b0;
        @(negedge sysClk);
        m_err[ch] = 1'b0;
        compare_all();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int ch;
        int sel;
        int nbits;
        logic [31:0] data;

        sysReset_n   = 1'b0;
        bus.spiClk   = '0;
        bus.spiSdi   = '0;
        bus.spiLe    = '1;
        bus.errClear = '0;
        model_reset();
        wait_n(3);
        check("reset_valid", bus.rxValid, 0);
        compare_all();
        sysReset_n = 1'b1;
        wait_n(SS + 5);
        check("post_reset_valid", bus.rxValid, 0);
        compare_all();

        // Basic good frame on ch0, ch1 stays untouched
        send_frame(0, 32'hA5, 8, 4, 1'b0, 1'b0);

        // Short then long frame on ch1, then clear
        send_frame(1, 32'h55, 7, 4, 1'b0, 1'b0);
        send_frame(1, 32'h1AB, 9, 4, 1'b0, 1'b0);
        clear_err(1);

        // Last SCLK rise coincident with LE rise
        send_frame(0, 32'h3C, 8, 4, 1'b1, 1'b0);

        // Clear in the same cycle as a new error: error wins
        send_frame(1, 32'h0B, 5, 4, 1'b0, 1'b1);
        clear_err(1);

        // SCLK activity while LE is high must be ignored
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            bus.spiSdi[1] = 1'(i);
            bus.spiClk[1] = 1'b1;
            for (int j = 0; j < 5; j++) begin
                @(negedge sysClk);
                if (bus.rxValid[1] === 1'b1) pulses++;
            end
            bus.spiClk[1] = 1'b0;
            for (int j = 0; j < 5; j++) begin
                @(negedge sysClk);
                if (bus.rxValid[1] === 1'b1) pulses++;
            end
        end
        wait_n(SS + 4);
        check("idle_sclk_valid", pulses, 0);
        compare_all();

        // Randomized frames: mostly good, some short/long/empty/far-too-long
        for (int r = 0; r < 24; r++) begin
            ch  = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            case (sel)
                6:       nbits = 7;
                7:       nbits = 9;
                8:       nbits = 24;
                9:       nbits = 0;
                default: nbits = 8;
            endcase
            data = $urandom;
            send_frame(ch, data, nbits, int'($urandom_range(4, 6)),
                       (nbits > 0) && ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 2) == 0) clear_err(ch);
        end

        // Reset in the middle of a frame discards the partial bits
        bus.spiLe[0] = 1'b0;
        wait_n(4);
        for (int i = 0; i < 4; i++) begin
            bus.spiSdi[0] = 1'b1;
            wait_n(4);
            bus.spiClk[0] = 1'b1;
            wait_n(4);
            bus.spiClk[0] = 1'b0;
        end
        sysReset_n = 1'b0;
        model_reset();
        wait_n(3);
        check("midreset_valid", bus.rxValid, 0);
        compare_all();
        sysReset_n = 1'b1;
        wait_n(3);
        bus.spiLe[0] = 1'b1;
        wait_n(SS + 6);
        compare_all();
        send_frame(0, 32'h81, 8, 4, 1'b0, 1'b0);

        // Counter wrap from all-ones
        force u_dut.g_chan[0].u_chan.frame_count = 16'hFFFF;
        @(negedge sysClk);
        release u_dut.g_chan[0].u_chan.frame_count;
        @(negedge sysClk);
        m_cnt[0] = 16'hFFFF;
        compare_all();
        send_frame(0, 32'h6E, 8, 4, 1'b0, 1'b0);
        check("wrap_count", bus.rxCount[CW-1:0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
